// File: rtl/systolic_result_drain.sv
// Read-out end of the NxN systolic array: waits out a job, snapshots every PE
// accumulator, clears the PEs and streams the results row-major over valid/ready.
module systolic_result_drain #(
  parameter int unsigned N        = 4,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [15:0]                k_len,
  input  logic [N*N*DATA_W-1:0]      pe_res,
  output logic                       pe_rst_n,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic [$clog2(N*N)-1:0]     out_idx,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned NW      = N * N;
  localparam int unsigned IDX_W   = $clog2(NW);
  localparam int unsigned CNT_W   = 17;
  localparam int unsigned CNT_ADD = 2 * (N - 1) + PIPE_LAT - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CAPTURE,
    S_STREAM,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic                r_pe_clr;
  logic [DATA_W-1:0]   r_buf [NW];
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_valid;
  logic                r_out_last;
  logic                r_busy;
  logic                r_done;

  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic                w_pe_clr_nxt;
  logic [DATA_W-1:0]   w_out_data_nxt;
  logic                w_valid_nxt;
  logic                w_last_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic                w_capture;
  logic                w_xfer;

  assign w_xfer = r_out_valid & out_ready;

  // Next-state and next-output logic; registered outputs are loaded from these.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_idx_nxt      = r_idx;
    w_pe_clr_nxt   = 1'b1;
    w_out_data_nxt = r_out_data;
    w_valid_nxt    = 1'b0;
    w_done_nxt     = 1'b0;
    w_capture      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start && (k_len != 16'd0)) begin
          w_cnt_nxt   = CNT_W'(k_len) + CNT_W'(CNT_ADD);
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == CNT_W'(0)) begin
          w_state_nxt = S_CAPTURE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_CAPTURE: begin
        // Snapshot lands this edge, so word 0 is taken straight from the array.
        w_capture      = 1'b1;
        w_pe_clr_nxt   = 1'b0;
        w_idx_nxt      = '0;
        w_valid_nxt    = 1'b1;
        w_out_data_nxt = pe_res[DATA_W-1:0];
        w_state_nxt    = S_STREAM;
      end
      S_STREAM: begin
        w_valid_nxt = 1'b1;
        if (w_xfer) begin
          if (r_idx == LAST_IDX) begin
            w_valid_nxt = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_idx_nxt      = r_idx + IDX_W'(1);
            w_out_data_nxt = r_buf[w_idx_nxt];
          end
        end
      end
      S_DONE: begin
        w_idx_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_last_nxt = w_valid_nxt && (w_idx_nxt == LAST_IDX);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_pe_clr    <= 1'b1;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_pe_clr    <= w_pe_clr_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_valid_nxt;
      r_out_last  <= w_last_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  // Snapshot buffer isolates the stream from the array once the PEs are cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NW; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_capture) begin
      for (int i = 0; i < NW; i++) begin
        r_buf[i] <= pe_res[i*DATA_W +: DATA_W];
      end
    end
  end

  assign pe_rst_n  = rst & r_pe_clr;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_idx   = r_idx;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain: latency, PE clear, snapshot isolation,
// backpressure, ignored starts, mid-stream reset and a back-to-back max-length job.
module tb_systolic_result_drain;

  localparam int N        = 4;
  localparam int DW       = 32;
  localparam int PIPE_LAT = 2;
  localparam int NW       = N * N;
  localparam int IDX_W    = $clog2(NW);

  logic                clk;
  logic                rst;
  logic                start;
  logic [15:0]         k_len;
  logic [NW*DW-1:0]    pe_res;
  logic                pe_rst_n;
  logic [DW-1:0]       out_data;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;
  logic [IDX_W-1:0]    out_idx;
  logic                busy;
  logic                done;

  int n_checks = 0;
  int n_errs   = 0;
  int done_cnt = 0;

  systolic_result_drain #(.N(N), .DATA_W(DW), .PIPE_LAT(PIPE_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .k_len     (k_len),
    .pe_res    (pe_res),
    .pe_rst_n  (pe_rst_n),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_idx   (out_idx),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_pe(input logic [31:0] base, input bit scramble);
    for (int i = 0; i < NW; i++) begin
      pe_res[i*DW +: DW] = scramble ? ~(base + 32'(i)) : (base + 32'(i));
    end
  endtask

  // Drives one job from a negedge in IDLE; returns on the negedge after done
  // (or one cycle after an abort reset).
  task automatic run_job(input logic [15:0] k, input logic [31:0] base, input bit bp,
                         input bit inject, input int abort_after);
    int cyc, n, s, guard, lat_exp;
    bit rdy, prev_stall;
    logic [DW-1:0] prev_data;
    logic [IDX_W-1:0] prev_idx;
    lat_exp = int'(k) + 2 * (N - 1) + PIPE_LAT + 2;
    set_pe(base, 1'b0);
    k_len = k;
    start = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      start = inject && (cyc == 3);
    end while (!out_valid && cyc < lat_exp + 20);
    start = 1'b0;
    check("latency", cyc, lat_exp);
    check("pe_clr_low", pe_rst_n, 0);
    set_pe(base, 1'b1);
    n = 0; s = 0; guard = 0; prev_stall = 1'b0; prev_data = '0; prev_idx = '0;
    while (n < NW && guard < 600) begin
      if (abort_after != 0 && n == abort_after) begin
        out_ready = 1'b0;
        start = 1'b0;
        rst = 1'b0;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_pe_rst", pe_rst_n, 0);
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      if (guard == 1) check("pe_clr_high", pe_rst_n, 1);
      if (prev_stall) begin
        check("stall_data", out_data, prev_data);
        check("stall_idx", out_idx, prev_idx);
      end
      if (!bp) rdy = 1'b1;
      else begin
        case (s)
          0, 3:    rdy = 1'b1;
          1, 2:    rdy = 1'b0;
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        s++;
      end
      out_ready = rdy;
      start = inject && (n == 5);
      check("valid_held", out_valid, 1);
      if (out_valid && rdy) begin
        check("idx", out_idx, n);
        check("data", out_data, base + 32'(n));
        check("last", out_last, (n == NW - 1));
        n++;
      end
      prev_stall = out_valid && !rdy;
      prev_data = out_data;
      prev_idx = out_idx;
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    out_ready = 1'b0;
    if (n != NW) check("stream_timeout", n, NW);
    check("done_pulse", done, 1);
    check("done_valid", out_valid, 0);
    @(negedge clk);
    check("done_once", done, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    int d0;
    rst = 1'b0; start = 1'b0; k_len = '0; out_ready = 1'b0; pe_res = '0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_data", out_data, 0);
    check("rst_idx", out_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pe_rst", pe_rst_n, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("pe_rst_release", pe_rst_n, 1);
    @(negedge clk);

    // k_len == 0 start is ignored
    start = 1'b1; k_len = 16'd0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("k0_busy", busy, 0);
      @(negedge clk);
    end

    d0 = done_cnt;
    run_job(16'd5, 32'h3F80_0000, 1'b0, 1'b0, 0);
    check("job_a_dones", done_cnt - d0, 1);

    d0 = done_cnt;
    run_job(16'd3, 32'h4000_0000, 1'b1, 1'b1, 0);
    repeat (20) @(negedge clk);
    check("job_b_dones", done_cnt - d0, 1);
    check("job_b_idle", busy, 0);

    d0 = done_cnt;
    run_job(16'd4, 32'h4100_0000, 1'b0, 1'b0, 7);
    repeat (10) @(negedge clk);
    check("abort_dones", done_cnt - d0, 0);
    check("abort_idle", busy, 0);
    check("abort_novalid", out_valid, 0);

    d0 = done_cnt;
    run_job(16'd1, 32'h4200_0000, 1'b0, 1'b0, 0);
    run_job(16'hFFFF, 32'h4300_0000, 1'b0, 1'b0, 0);
    check("b2b_dones", done_cnt - d0, 2);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
